// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader: streams 3-byte words into program memory, then checks a checksum.
module prog_loader #(
  parameter int Psize = 4,
  parameter int Isize = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             we,
  output logic [Psize-1:0] waddr,
  output logic [Isize-1:0] wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;

  state_t           state;
  logic [1:0]       byte_idx;
  logic [Psize-1:0] word_idx;
  logic [7:0]       csum;
  logic [3:0]       b0_nib;
  logic [7:0]       b1;
  logic             accept;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rx_ready <= 1'b0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_idx <= 2'd0;
      word_idx <= '0;
      csum     <= 8'd0;
      b0_nib   <= 4'd0;
      b1       <= 8'd0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= LOAD;
            rx_ready <= 1'b1;
            byte_idx <= 2'd0;
            word_idx <= '0;
            csum     <= 8'd0;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            // the checksum covers the full first byte, even though only its low nibble is data
            csum <= csum + rx_data;
            case (byte_idx)
              2'd0: begin
                b0_nib   <= rx_data[3:0];
                byte_idx <= 2'd1;
              end
              2'd1: begin
                b1       <= rx_data;
                byte_idx <= 2'd2;
              end
              default: begin
                byte_idx <= 2'd0;
                we       <= 1'b1;
                waddr    <= word_idx;
                wdata    <= {b0_nib, b1, rx_data};
                word_idx <= word_idx + 1'b1;
                if (word_idx == '1) state <= CHECK;
              end
            endcase
          end
        end
        CHECK: begin
          if (accept) begin
            err      <= (rx_data != csum);
            cpu_hold <= (rx_data != csum);
            done     <= 1'b1;
            rx_ready <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader with a byte-count reference model.
module tb_prog_loader;
  localparam int PS = 4;
  localparam int NW = 1 << PS;
  localparam int NB = 3 * NW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic          rx_ready, we, cpu_hold, done, err;
  logic [PS-1:0] waddr;
  logic [19:0]   wdata;

  prog_loader #(.Psize(PS), .Isize(20)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a load is just the list of bytes accepted since start.
  bit          m_active = 0;
  int          m_n = 0;
  logic [7:0]  m_bytes [0:NB];
  bit          m_we = 0;
  int          m_waddr = 0;
  logic [19:0] m_wdata = 0;

  function automatic logic [7:0] m_sum();
    logic [7:0] s = 8'd0;
    for (int i = 0; i < NB; i++) s = s + m_bytes[i];
    return s;
  endfunction

  function automatic bit m_done();
    return m_active && m_n == NB + 1;
  endfunction

  function automatic bit m_err();
    return m_done() && (m_sum() != m_bytes[NB]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_active = 0;
      m_n = 0;
      m_we = 0;
    end else begin
      m_we = 0;
      if ((!m_active || m_n == NB + 1) && start) begin
        m_active = 1;
        m_n = 0;
      end else if (m_active && m_n <= NB && rx_valid) begin
        m_bytes[m_n] = rx_data;
        m_n++;
        if (m_n % 3 == 0 && m_n <= NB) begin
          m_we = 1;
          m_waddr = m_n / 3 - 1;
          m_wdata = {m_bytes[m_n-3][3:0], m_bytes[m_n-2], m_bytes[m_n-1]};
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rx_ready", 32'(rx_ready), 32'(m_active && m_n <= NB));
    chk("we", 32'(we), 32'(m_we));
    chk("done", 32'(done), 32'(m_done()));
    chk("err", 32'(err), 32'(m_err()));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_active && !(m_done() && !m_err())));
    if (m_we) begin
      chk("waddr", 32'(waddr), 32'(m_waddr));
      chk("wdata", 32'(wdata), 32'(m_wdata));
    end
    if (we) wcount++;
  end

  task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
    reset = r;
    start = s;
    rx_valid = v;
    rx_data = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap, input bit noise);
    for (int g = 0; g < gap; g++) step(0, noise ? 1'($urandom) : 1'b0, 1'b0, 8'($urandom));
    step(0, 0, 1, d);
  endtask

  task automatic load_ones(input logic [7:0] cs, input int gap, input bit noise);
    step(0, 1, 0, 8'h00);
    wcount = 0;
    for (int i = 0; i < NB; i++) send_byte(8'h01, gap, noise);
    send_byte(cs, gap, noise);
  endtask

  logic [7:0] ps;

  initial begin
    step(1, 1, 1, 8'hFF);
    step(1, 0, 0, 8'h00);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd0);
    chk("rst_waddr", 32'(waddr), 32'd0);
    chk("rst_wdata", 32'(wdata), 32'd0);

    // ignored bytes in IDLE, then single word
    step(0, 0, 1, 8'h55);
    step(0, 1, 0, 8'h00);
    chk("idle_hold", 32'(cpu_hold), 32'd1);
    send_byte(8'h0A, 0, 0);
    send_byte(8'hBC, 0, 0);
    send_byte(8'hDE, 0, 0);
    chk("w0_we", 32'(we), 32'd1);
    chk("w0_waddr", 32'(waddr), 32'd0);
    chk("w0_wdata", 32'(wdata), 32'hABCDE);
    step(1, 0, 0, 8'h00);

    // nibble mask
    step(0, 1, 0, 8'h00);
    send_byte(8'hFA, 0, 0);
    send_byte(8'hBC, 1, 0);
    send_byte(8'hDE, 0, 0);
    chk("mask_wdata", 32'(wdata), 32'hABCDE);
    ps = m_bytes[0] + m_bytes[1] + m_bytes[2];
    chk("mask_psum", 32'(ps), 32'h94);
    step(1, 0, 0, 8'h00);

    // full good load
    load_ones(8'h30, 0, 0);
    chk("good_done", 32'(done), 32'd1);
    chk("good_err", 32'(err), 32'd0);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_wcount", 32'(wcount), 32'd16);
    step(0, 0, 1, 8'h77);
    chk("done_ready", 32'(rx_ready), 32'd0);

    // bad checksum, started from DONE
    load_ones(8'h31, 0, 0);
    chk("bad_done", 32'(done), 32'd1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_hold", 32'(cpu_hold), 32'd1);

    // backpressure and ignored start
    load_ones(8'h30, 1, 1);
    chk("bp_wcount", 32'(wcount), 32'd16);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_err", 32'(err), 32'd0);

    // reset after word 4
    step(0, 1, 0, 8'h00);
    wcount = 0;
    for (int i = 0; i < 15; i++) send_byte(8'($urandom), 0, 0);
    chk("mid_waddr", 32'(waddr), 32'd4);
    step(1, 0, 1, 8'h12);
    chk("mid_ready", 32'(rx_ready), 32'd0);
    chk("mid_hold", 32'(cpu_hold), 32'd0);
    chk("mid_we", 32'(we), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'($urandom));
    chk("mid_wcount", 32'(wcount), 32'd5);
    step(0, 1, 0, 8'h00);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 0, 0);
    chk("reload_waddr", 32'(waddr), 32'd0);
    step(1, 0, 0, 8'h00);

    // random loads
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 1'($urandom), 8'($urandom));
      for (int i = 0; i < NB; i++) send_byte(8'($urandom), $urandom_range(0, 2), 1);
      send_byte(m_sum() + (($urandom % 2) ? 8'd1 : 8'd0), $urandom_range(0, 2), 1);
      for (int i = 0; i < 3; i++) step(0, 0, 1'($urandom), 8'($urandom));
      if (k == 3) begin
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), $urandom_range(0, 1), 1);
        step(1, 1'($urandom), 1'($urandom), 8'($urandom));
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter Psize, default 4, program-memory address width (memory depth 2^Psize words).
REQ-002 SHALL have parameter Isize, default 20, instruction width; Isize SHALL be fixed at 20 for this block.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a program load.
REQ-006 SHALL have port rx_data  input  8  incoming program byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data is valid this cycle.
REQ-008 SHALL have port rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port we  output  1  program-memory write strobe, one cycle per word.
REQ-010 SHALL have port waddr  output  Psize  program-memory write address.
REQ-011 SHALL have port wdata  output  Isize  instruction word to write.
REQ-012 SHALL have port cpu_hold  output  1  holds the picoMIPS core (PC and fetch) stalled while high.
REQ-013 SHALL have port done  output  1  load sequence finished.
REQ-014 SHALL have port err  output  1  checksum mismatch on the last load.

Function
REQ-015 SHALL implement states IDLE, LOAD, CHECK, DONE.
REQ-016 A byte SHALL transfer only on a rising edge where rx_valid=1 and rx_ready=1; rx_valid=0 cycles SHALL stall without losing state.
REQ-017 rx_ready SHALL be 1 in LOAD and CHECK and 0 in IDLE and DONE.
REQ-018 IDLE: start=1 -> LOAD next cycle; word index, byte index and checksum cleared to 0; cpu_hold=1; done=0; err=0.
REQ-019 LOAD: each word SHALL be 3 bytes, MS first: wdata = {b0[3:0], b1[7:0], b2[7:0]}; b0[7:4] ignored for data.
REQ-020 Checksum SHALL be an 8-bit modulo-256 sum of all 3*2^Psize received data bytes, all 8 bits of each (including b0[7:4]).
REQ-021 we SHALL pulse high for exactly one cycle, the cycle after the edge accepting b2, with waddr = word index and wdata stable in that cycle.
REQ-022 Word index SHALL increment by 1 after each write; writes SHALL be in order 0..2^Psize-1, no wrap.
REQ-023 The edge accepting b2 of word 2^Psize-1 SHALL move LOAD -> CHECK; that word's we pulse occurs in the first CHECK cycle.
REQ-024 CHECK: the next accepted byte is the checksum; equal to the running sum -> err=0, else err=1; -> DONE next cycle.
REQ-025 DONE: done=1; cpu_hold=0 if err=0, cpu_hold=1 if err=1; we=0.
REQ-026 start SHALL be ignored in LOAD and CHECK; start in DONE SHALL behave as in IDLE (REQ-018) and re-load from word 0.
REQ-027 rx_valid in IDLE or DONE SHALL be ignored (no byte consumed, no state change).
REQ-028 we, waddr, wdata SHALL be registered outputs; when we=0, waddr and wdata are don't-care.

Reset
REQ-029 On reset=1 at a rising edge: state=IDLE, we=0, rx_ready=0, cpu_hold=0, done=0, err=0, waddr=0, wdata=0, byte/word index and checksum =0.
REQ-030 reset SHALL take priority over start, rx_valid and any in-progress load; no we pulse SHALL occur the cycle after reset is applied; memory contents already written are not restored.

Verification
REQ-031 Single word: start, bytes 0x0A,0xBC,0xDE -> one cycle after the 0xDE edge, we=1, waddr=0, wdata=0xABCDE.
REQ-032 Nibble mask: first word 0xFA,0xBC,0xDE -> wdata=0xABCDE; checksum includes 0xFA (partial sum 0x94).
REQ-033 Full good load: 48 bytes of 0x01, then checksum 0x30 -> 16 we pulses at waddr 0..15, wdata=0x10101 each, then done=1, err=0, cpu_hold=0.
REQ-034 Bad checksum: same stream, checksum 0x31 -> done=1, err=1, cpu_hold=1.
REQ-035 Backpressure/ignore: rx_valid toggled 1,0,1 between bytes and start pulsed mid-LOAD -> identical we sequence to REQ-033, no restart.
REQ-036 Reset mid-load after word 4 written -> next cycle IDLE, rx_ready=0, cpu_hold=0, no further we; a new start reloads from waddr=0.
